// File: rtl/id_load_scoreboard_if.sv
// Decode-stage bundle between the decoder/pipeline control (master) and the
// load scoreboard hazard unit (slave).
interface id_load_scoreboard_if #(
    parameter int REG_WIDTH = 5,
    parameter int NUM_FWD   = 3,
    parameter int CNT_WIDTH = 16
);
    localparam int SEL_WIDTH = $clog2(NUM_FWD + 1);

    logic                         valid;
    logic [REG_WIDTH-1:0]         rs1;
    logic [REG_WIDTH-1:0]         rs2;
    logic                         rs1_used;
    logic                         rs2_used;
    logic [REG_WIDTH-1:0]         rd;
    logic                         reg_wr_en;
    logic                         is_load;
    logic                         flush;
    logic                         ex_ready;
    logic [NUM_FWD*REG_WIDTH-1:0] fwd_addr;
    logic [NUM_FWD-1:0]           fwd_en;
    logic [SEL_WIDTH-1:0]         data_a_sel;
    logic [SEL_WIDTH-1:0]         data_b_sel;
    logic                         stall;
    logic                         sb_full;
    logic                         issue_valid;
    logic [REG_WIDTH-1:0]         issue_rd;
    logic [CNT_WIDTH-1:0]         stall_count;

    modport master (
        output valid, rs1, rs2, rs1_used, rs2_used, rd, reg_wr_en, is_load,
               flush, ex_ready, fwd_addr, fwd_en,
        input  data_a_sel, data_b_sel, stall, sb_full, issue_valid, issue_rd,
               stall_count
    );

    modport slave (
        input  valid, rs1, rs2, rs1_used, rs2_used, rd, reg_wr_en, is_load,
               flush, ex_ready, fwd_addr, fwd_en,
        output data_a_sel, data_b_sel, stall, sb_full, issue_valid, issue_rd,
               stall_count
    );
endinterface

// File: rtl/id_load_scoreboard.sv
// Decode-stage hazard unit: operand forward select, in-flight load scoreboard,
// load-use stall, registered issue strobe toward EX and saturating stall counter.
module id_load_scoreboard #(
    parameter int REG_WIDTH = 5,
    parameter int NUM_FWD   = 3,
    parameter int SB_DEPTH  = 4,
    parameter int LOAD_LAT  = 2,
    parameter int CNT_WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    id_load_scoreboard_if.slave bus
);
    localparam int SEL_WIDTH = $clog2(NUM_FWD + 1);
    localparam int LAT_WIDTH = $clog2(LOAD_LAT + 1);

    logic [REG_WIDTH-1:0] sb_rd  [SB_DEPTH];
    logic [LAT_WIDTH-1:0] sb_cnt [SB_DEPTH];
    logic [SB_DEPTH-1:0]  busy;
    logic [SB_DEPTH-1:0]  alloc;
    logic                 alloc_taken;
    logic [SEL_WIDTH-1:0] sel_a;
    logic [SEL_WIDTH-1:0] sel_b;
    logic                 hit_rs1;
    logic                 hit_rs2;
    logic                 hazard;
    logic                 ld_alloc;
    logic                 sb_full;
    logic                 fire;
    logic                 stall;
    logic                 issue_valid;
    logic [REG_WIDTH-1:0] issue_rd;
    logic [CNT_WIDTH-1:0] stall_count;

    // Walk from oldest to youngest so the youngest matching source wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (bus.fwd_en[k] && bus.fwd_addr[k*REG_WIDTH +: REG_WIDTH] == bus.rs1)
                sel_a = SEL_WIDTH'(k + 1);
            if (bus.fwd_en[k] && bus.fwd_addr[k*REG_WIDTH +: REG_WIDTH] == bus.rs2)
                sel_b = SEL_WIDTH'(k + 1);
        end
        if (!bus.rs1_used || bus.rs1 == '0)
            sel_a = '0;
        if (!bus.rs2_used || bus.rs2 == '0)
            sel_b = '0;
    end

    always_comb begin
        busy    = '0;
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            busy[i] = (sb_cnt[i] != '0);
            if (sb_cnt[i] != '0 && sb_rd[i] == bus.rs1)
                hit_rs1 = 1'b1;
            if (sb_cnt[i] != '0 && sb_rd[i] == bus.rs2)
                hit_rs2 = 1'b1;
        end
    end

    assign hazard   = bus.valid && ((bus.rs1_used && bus.rs1 != '0 && hit_rs1) ||
                                    (bus.rs2_used && bus.rs2 != '0 && hit_rs2));
    assign ld_alloc = bus.is_load && bus.reg_wr_en && bus.rd != '0;
    assign sb_full  = &busy;
    assign fire     = bus.valid && !bus.flush && !hazard && bus.ex_ready &&
                      !(ld_alloc && sb_full);
    assign stall    = bus.valid && !bus.flush && !fire;

    // fire with ld_alloc implies not full, so a free entry always exists here.
    always_comb begin
        alloc       = '0;
        alloc_taken = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (!busy[i] && !alloc_taken) begin
                alloc[i]    = fire && ld_alloc;
                alloc_taken = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (alloc[i])
                sb_rd[i] <= bus.rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++)
                sb_cnt[i] <= '0;
            issue_valid <= 1'b0;
            issue_rd    <= '0;
            stall_count <= '0;
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (alloc[i])
                    sb_cnt[i] <= LAT_WIDTH'(LOAD_LAT);
                else if (busy[i])
                    sb_cnt[i] <= sb_cnt[i] - LAT_WIDTH'(1);
            end
            issue_valid <= fire;
            issue_rd    <= fire ? bus.rd : '0;
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

    assign bus.data_a_sel  = sel_a;
    assign bus.data_b_sel  = sel_b;
    assign bus.stall       = stall;
    assign bus.sb_full     = sb_full;
    assign bus.issue_valid = issue_valid;
    assign bus.issue_rd    = issue_rd;
    assign bus.stall_count = stall_count;
endmodule
